// File: rtl/sm83_pkg.sv
// Shared types and constants for the sm83 interrupt controller.
package sm83_pkg;

    localparam int         SM83_WORD_SIZE  = 8;
    localparam int         SM83_NUM_IRQS   = 5;
    localparam logic [7:0] SM83_VEC_BASE   = 8'h40;
    localparam int         SM83_VEC_STRIDE = 8;

    typedef logic [SM83_WORD_SIZE-1:0] word_t;
    typedef logic [SM83_NUM_IRQS-1:0]  irq_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        ACK      = 2'd2
    } irq_state_t;

endpackage

// File: rtl/sm83_irq_prio.sv
// Fixed-priority encoder: lowest set index of pend wins.
module sm83_irq_prio
    import sm83_pkg::*;
#(
    parameter int N     = SM83_NUM_IRQS,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     pend,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scanning downwards lets the lowest index overwrite any higher hit.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm83_irq_ctl.sv
// sm83 interrupt controller: IF/IE/IME, EI delay, dispatch sequencing, vector and acknowledge.
// Define SM83_IRQ_HALT_BUG_EN to add the halt_bug output.
//
// state    | meaning
// IDLE     | no dispatch in progress
// DISPATCH | control unit is pushing PC; waiting for vec_sample
// ACK      | vector latched, iack issued; return to IDLE next M-cycle
module sm83_irq_ctl
    import sm83_pkg::*;
#(
    parameter int                   WORD_SIZE = SM83_WORD_SIZE,
    parameter int                   NUM_IRQS  = SM83_NUM_IRQS,
    parameter logic [WORD_SIZE-1:0] VEC_BASE  = SM83_VEC_BASE
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 mcyc_end,
    input  logic [NUM_IRQS-1:0]  irq_in,
    input  logic                 reg_if_sel,
    input  logic                 reg_ie_sel,
    input  logic                 reg_we,
    input  logic [WORD_SIZE-1:0] reg_din,
    output logic [WORD_SIZE-1:0] reg_dout,
    input  logic                 ei,
    input  logic                 di,
    input  logic                 reti,
    input  logic                 instr_end,
    input  logic                 halted,
    input  logic                 dispatch_start,
    input  logic                 vec_sample,
    output logic                 int_req,
    output logic                 wake,
    output logic [WORD_SIZE-1:0] vec,
`ifdef SM83_IRQ_HALT_BUG_EN
    output logic                 halt_bug,
`endif
    output logic [NUM_IRQS-1:0]  iack
);

    localparam int IDX_W = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

    logic [NUM_IRQS-1:0]  irq_prev;
    logic [NUM_IRQS-1:0]  if_q;
    logic [WORD_SIZE-1:0] ie_q;
    logic                 ime;
    logic [1:0]           ei_cnt;
    irq_state_t           state;

    logic [NUM_IRQS-1:0]  set_mask;
    logic [NUM_IRQS-1:0]  pend;
    logic [NUM_IRQS-1:0]  ack_mask;
    logic [NUM_IRQS-1:0]  if_next;
    logic [IDX_W-1:0]     prio_idx;
    logic                 prio_valid;
    logic                 ack_fire;
    logic                 if_wr;
    logic                 ie_wr;
    logic [WORD_SIZE-1:0] vec_hit;

    assign set_mask = irq_in & ~irq_prev;
    assign pend     = if_q & ie_q[NUM_IRQS-1:0];
    assign wake     = |pend;
    assign int_req  = ime & wake;
    assign if_wr    = reg_we & mcyc_end & reg_if_sel;
    assign ie_wr    = reg_we & mcyc_end & reg_ie_sel;
    assign ack_fire = mcyc_end & vec_sample & (state == DISPATCH);
    assign ack_mask = (ack_fire && prio_valid) ? (NUM_IRQS'(1) << prio_idx) : '0;
    assign vec_hit  = VEC_BASE + WORD_SIZE'(SM83_VEC_STRIDE) * WORD_SIZE'(prio_idx);

    sm83_irq_prio #(
        .N     (NUM_IRQS),
        .IDX_W (IDX_W)
    ) u_prio (
        .pend  (pend),
        .idx   (prio_idx),
        .valid (prio_valid)
    );

    // Hardware set beats acknowledge clear, which beats a CPU write.
    always_comb begin
        if_next = if_q;
        if (if_wr) begin
            if_next = reg_din[NUM_IRQS-1:0];
        end
        if_next = (if_next & ~ack_mask) | set_mask;
    end

    always_comb begin
        reg_dout = '0;
        if (reg_if_sel) begin
            reg_dout                 = '1;
            reg_dout[NUM_IRQS-1:0]   = if_q;
        end else if (reg_ie_sel) begin
            reg_dout = ie_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            irq_prev <= '0;
            if_q     <= '0;
            ie_q     <= '0;
        end else begin
            irq_prev <= irq_in;
            if_q     <= if_next;
            if (ie_wr) begin
                ie_q <= reg_din;
            end
        end
    end

    // ei_cnt counts the opcode fetches left before IME rises after EI.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            ime    <= 1'b0;
            ei_cnt <= 2'd0;
        end else if (mcyc_end) begin
            if (di || ack_fire) begin
                ime    <= 1'b0;
                ei_cnt <= 2'd0;
            end else begin
                if (reti) begin
                    ime <= 1'b1;
                end
                if (ei) begin
                    ei_cnt <= 2'd2;
                end else if (ei_cnt != 2'd0 && instr_end) begin
                    ei_cnt <= ei_cnt - 2'd1;
                    if (ei_cnt == 2'd1) begin
                        ime <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state <= IDLE;
            vec   <= '0;
            iack  <= '0;
        end else begin
            iack <= ack_mask;
            if (mcyc_end) begin
                case (state)
                    IDLE: begin
                        if (dispatch_start && int_req) begin
                            state <= DISPATCH;
                        end
                    end
                    DISPATCH: begin
                        if (vec_sample) begin
                            state <= ACK;
                            vec   <= prio_valid ? vec_hit : '0;
                        end
                    end
                    ACK:     state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SM83_IRQ_HALT_BUG_EN
    logic halted_prev;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            halted_prev <= 1'b0;
            halt_bug    <= 1'b0;
        end else if (mcyc_end) begin
            halted_prev <= halted;
            halt_bug    <= halted & ~halted_prev & ~ime & wake;
        end
    end
`else
    logic unused_halted;
    assign unused_halted = halted;
`endif

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Randomized and directed bench for sm83_irq_ctl against a behavioural model.
module tb_sm83_irq_ctl;
    import sm83_pkg::*;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       mcyc_end = 1'b0;
    logic [4:0] irq_in = '0;
    logic       reg_if_sel = 1'b0;
    logic       reg_ie_sel = 1'b0;
    logic       reg_we = 1'b0;
    logic [7:0] reg_din = '0;
    logic [7:0] reg_dout;
    logic       ei = 1'b0;
    logic       di = 1'b0;
    logic       reti = 1'b0;
    logic       instr_end = 1'b0;
    logic       halted = 1'b0;
    logic       dispatch_start = 1'b0;
    logic       vec_sample = 1'b0;
    logic       int_req;
    logic       wake;
    logic [7:0] vec;
    logic [4:0] iack;
`ifdef SM83_IRQ_HALT_BUG_EN
    logic       halt_bug;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit [4:0] m_if, m_prev, m_iack;
    bit [7:0] m_ie, m_vec;
    bit       m_ime, m_hprev, m_hb;
    int       m_eiwait, m_phase;

    sm83_irq_ctl dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .mcyc_end       (mcyc_end),
        .irq_in         (irq_in),
        .reg_if_sel     (reg_if_sel),
        .reg_ie_sel     (reg_ie_sel),
        .reg_we         (reg_we),
        .reg_din        (reg_din),
        .reg_dout       (reg_dout),
        .ei             (ei),
        .di             (di),
        .reti           (reti),
        .instr_end      (instr_end),
        .halted         (halted),
        .dispatch_start (dispatch_start),
        .vec_sample     (vec_sample),
        .int_req        (int_req),
        .wake           (wake),
        .vec            (vec),
`ifdef SM83_IRQ_HALT_BUG_EN
        .halt_bug       (halt_bug),
`endif
        .iack           (iack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: one clk edge, written from the behavioural rules with ints and loops.
    task automatic model_edge();
        bit [4:0] pend, setm, ackm, nif;
        bit       old_req, old_wake, fire;
        int       lo;
        if (!n_reset) begin
            m_if = '0; m_ie = '0; m_ime = 0; m_eiwait = 0; m_phase = 0;
            m_vec = '0; m_iack = '0; m_prev = '0; m_hprev = 0; m_hb = 0;
            return;
        end
        pend     = m_if & m_ie[4:0];
        old_wake = (pend != 0);
        old_req  = m_ime && old_wake;
        setm     = irq_in & ~m_prev;
        m_prev   = irq_in;
        fire     = mcyc_end && (m_phase == 1) && vec_sample;
        ackm     = '0;
        if (fire) begin
            lo = -1;
            for (int i = 0; i < 5; i++) if (pend[i] && lo < 0) lo = i;
            m_vec = (lo >= 0) ? 8'(8'h40 + 8 * lo) : 8'h00;
            if (lo >= 0) ackm[lo] = 1'b1;
        end
        m_iack = ackm;
        nif = m_if;
        if (mcyc_end && reg_we && reg_if_sel) nif = reg_din[4:0];
        m_if = (nif & ~ackm) | setm;
        if (mcyc_end && reg_we && reg_ie_sel) m_ie = reg_din;
        if (mcyc_end) begin
            m_hb    = halted && !m_hprev && !m_ime && old_wake;
            m_hprev = halted;
            if (di || fire) begin
                m_ime = 0;
                m_eiwait = 0;
            end else begin
                if (reti) m_ime = 1;
                if (ei) m_eiwait = 2;
                else if (m_eiwait > 0 && instr_end) begin
                    m_eiwait--;
                    if (m_eiwait == 0) m_ime = 1;
                end
            end
            case (m_phase)
                0:       if (dispatch_start && old_req) m_phase = 1;
                1:       if (vec_sample) m_phase = 2;
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        bit [7:0] exp_dout;
        exp_dout = reg_if_sel ? {3'b111, m_if} : (reg_ie_sel ? m_ie : 8'h00);
        check("int_req", 32'(int_req), 32'(m_ime && ((m_if & m_ie[4:0]) != 0)));
        check("wake", 32'(wake), 32'((m_if & m_ie[4:0]) != 0));
        check("vec", 32'(vec), 32'(m_vec));
        check("iack", 32'(iack), 32'(m_iack));
        check("reg_dout", 32'(reg_dout), 32'(exp_dout));
`ifdef SM83_IRQ_HALT_BUG_EN
        check("halt_bug", 32'(halt_bug), 32'(m_hb));
`endif
    endtask

    task automatic clk_cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clear_strobes();
        reg_if_sel = 0; reg_ie_sel = 0; reg_we = 0; reg_din = '0;
        ei = 0; di = 0; reti = 0; instr_end = 0;
        dispatch_start = 0; vec_sample = 0;
    endtask

    // One 4-clk M-cycle; mcyc_end on the last clk. set_last raises irq bits just before that edge.
    task automatic run_mcyc(input bit rnd_irq, input logic [4:0] set_last);
        for (int t = 0; t < 4; t++) begin
            mcyc_end = (t == 3);
            if (rnd_irq)
                for (int b = 0; b < 5; b++)
                    if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
            if (t == 3) irq_in = irq_in | set_last;
            clk_cycle();
        end
        mcyc_end = 0;
    endtask

    task automatic mc();
        run_mcyc(1'b0, 5'b0);
        clear_strobes();
    endtask

    task automatic wr(input bit is_if, input logic [7:0] d);
        reg_if_sel = is_if; reg_ie_sel = !is_if; reg_we = 1; reg_din = d;
        mc();
    endtask

    task automatic read_if(input string tag, input logic [7:0] exp);
        reg_if_sel = 1;
        #1;
        check(tag, 32'(reg_dout), 32'(exp));
        reg_if_sel = 0;
    endtask

    task automatic do_reset();
        clear_strobes();
        n_reset = 0;
        clk_cycle();
        clk_cycle();
        n_reset = 1;
    endtask

    initial begin
        clear_strobes();
        do_reset();
        check("rst_int_req", 32'(int_req), 32'h0);
        check("rst_wake", 32'(wake), 32'h0);
        check("rst_vec", 32'(vec), 32'h0);
        check("rst_iack", 32'(iack), 32'h0);

        // Single request on line 2
        wr(1'b0, 8'h1F);
        reti = 1; mc();
        irq_in = 5'b00100; mc(); irq_in = '0;
        check("t1_int_req", 32'(int_req), 32'h1);
        dispatch_start = 1; mc();
        vec_sample = 1; mc();
        check("t1_vec", 32'(vec), 32'h50);
        check("t1_iack", 32'(iack), 32'h04);
        clk_cycle();
        check("t1_iack_off", 32'(iack), 32'h0);
        read_if("t1_if", 8'hE0);
        check("t1_ime_clr", 32'(int_req), 32'h0);
        mc();

        // Priority: two pending, lowest first
        wr(1'b1, 8'h05);
        reti = 1; mc();
        dispatch_start = 1; mc();
        vec_sample = 1; mc();
        check("t2_vec0", 32'(vec), 32'h40);
        check("t2_iack0", 32'(iack), 32'h01);
        mc();
        reti = 1; mc();
        dispatch_start = 1; mc();
        vec_sample = 1; mc();
        check("t2_vec2", 32'(vec), 32'h50);
        check("t2_iack2", 32'(iack), 32'h04);
        mc();

        // Cancelled dispatch: IE cleared before vec_sample
        wr(1'b1, 8'h01);
        reti = 1; mc();
        dispatch_start = 1; mc();
        wr(1'b0, 8'h00);
        vec_sample = 1; mc();
        check("t3_vec", 32'(vec), 32'h00);
        check("t3_iack", 32'(iack), 32'h00);
        read_if("t3_if", 8'hE1);
        mc();

        // EI delay
        do_reset();
        wr(1'b0, 8'h1F);
        ei = 1; mc();
        instr_end = 1; mc();
        irq_in = 5'b00010; mc(); irq_in = '0;
        check("t4_ei_wait", 32'(int_req), 32'h0);
        instr_end = 1; mc();
        check("t4_ei_done", 32'(int_req), 32'h1);
        di = 1; mc();
        check("t4_di", 32'(int_req), 32'h0);
        ei = 1; di = 1; mc();
        instr_end = 1; mc();
        instr_end = 1; mc();
        check("t4_ei_di", 32'(int_req), 32'h0);

        // Hardware set beats a clearing write in the same edge
        do_reset();
        reg_if_sel = 1; reg_we = 1; reg_din = 8'h00;
        run_mcyc(1'b0, 5'b01000);
        clear_strobes();
        read_if("t5_if", 8'hE8);
        irq_in = '0;
        mc();

`ifdef SM83_IRQ_HALT_BUG_EN
        do_reset();
        wr(1'b0, 8'h01);
        wr(1'b1, 8'h01);
        halted = 1; mc();
        check("t6_halt_bug", 32'(halt_bug), 32'h1);
        mc();
        check("t6_halt_bug_off", 32'(halt_bug), 32'h0);
        halted = 0;
        mc();
`endif

        // Reset in the middle of a dispatch
        do_reset();
        wr(1'b0, 8'h01);
        wr(1'b1, 8'h01);
        reti = 1; mc();
        dispatch_start = 1; mc();
        n_reset = 0;
        clk_cycle();
        check("t7_int_req", 32'(int_req), 32'h0);
        check("t7_wake", 32'(wake), 32'h0);
        check("t7_vec", 32'(vec), 32'h0);
        check("t7_iack", 32'(iack), 32'h0);
        n_reset = 1;
        mc();

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(199) == 0) do_reset();
            reg_we         = ($urandom_range(7) == 0);
            reg_if_sel     = ($urandom_range(3) == 0);
            reg_ie_sel     = !reg_if_sel && ($urandom_range(2) == 0);
            reg_din        = 8'($urandom);
            ei             = ($urandom_range(9) == 0);
            di             = ($urandom_range(14) == 0);
            reti           = ($urandom_range(9) == 0);
            instr_end      = ($urandom_range(1) == 0);
            dispatch_start = ($urandom_range(3) == 0);
            vec_sample     = ($urandom_range(3) == 0);
            if ($urandom_range(15) == 0) halted = ~halted;
            run_mcyc(1'b1, 5'b0);
            clear_strobes();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
